// File: rtl/sb_traffic_pkg.sv
// Shared types and pattern helpers for the
// byte-increment loopback traffic engine.
package sb_traffic_pkg;

  localparam int SB_MAX_DW = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // byte i of word k = k*nbytes + i + seed (mod 256)
  function automatic logic [SB_MAX_DW-1:0] gen_word(
    input logic [15:0] k,
    input logic [7:0]  seed,
    input int unsigned nbytes
  );
    logic [SB_MAX_DW-1:0] w;
    logic [7:0]           base;
    base = 8'(32'(k) * nbytes + 32'(seed));
    for (int i = 0; i < SB_MAX_DW / 8; i++) begin
      w[i*8 +: 8] = base + 8'(i);
    end
    return w;
  endfunction

  // every byte + 1 with 8-bit wrap
  function automatic logic [SB_MAX_DW-1:0] incr_bytes(
    input logic [SB_MAX_DW-1:0] word
  );
    logic [SB_MAX_DW-1:0] w;
    for (int i = 0; i < SB_MAX_DW / 8; i++) begin
      w[i*8 +: 8] = word[i*8 +: 8] + 8'd1;
    end
    return w;
  endfunction

  // end of packet, or final word of the run
  function automatic logic pkt_last(
    input logic [15:0] k,
    input logic [15:0] n,
    input int unsigned pkt
  );
    return ((32'(k) % pkt) == pkt - 1) ||
           ((32'(k) + 1) == 32'(n));
  endfunction

endpackage

// File: rtl/sb_incr_traffic_checker_word_check.sv
// Returned-word comparator with a registered
// one-cycle mismatch strobe.
module sb_incr_word_check #(
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fire,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_last,
  input  logic [DW-1:0] exp_data,
  input  logic          exp_last,
  output logic          mismatch
);

  logic bad;

  assign bad = (rx_data != exp_data) ||
               (rx_last != exp_last);

  // strobe only for words actually transferred
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= fire && bad;
    end
  end

endmodule

// File: rtl/sb_incr_traffic_checker.sv
// Traffic engine: generates framed pattern words,
// checks the +1 loopback and reports run status.
module sb_incr_traffic_checker
  import sb_traffic_pkg::*;
#(
  parameter int         DW        = 256,
  parameter int         PKT_WORDS = 4,
  parameter logic [7:0] SEED      = 8'h00,
  parameter int         TIMEOUT   = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   num_words,
  output logic [DW-1:0] tx_data,
  output logic          tx_last,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_last,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic          timeout
);

  localparam int NB  = DW / 8;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST =
    WDW'(TIMEOUT - 1);

  state_t         state;
  logic [15:0]    num_lat;
  logic [15:0]    send_cnt;
  logic [15:0]    recv_cnt;
  logic [WDW-1:0] wd_cnt;
  logic           tx_fire;
  logic           rx_fire;
  logic           all_recv;
  logic           mismatch;
  logic [15:0]    err_next;
  logic [DW-1:0]  nxt_data;
  logic           nxt_last;
  logic [DW-1:0]  exp_data;
  logic           exp_last;

  assign tx_fire  = tx_valid && tx_ready;
  assign rx_fire  = rx_valid && rx_ready;
  assign all_recv = (recv_cnt == num_lat);
  assign rx_ready = (state == ST_RUN) &&
                    (recv_cnt < num_lat);

  assign nxt_data = DW'(gen_word(send_cnt,
                                 SEED, NB));
  assign nxt_last = pkt_last(send_cnt, num_lat,
                             PKT_WORDS);
  assign exp_data = DW'(incr_bytes(
                      gen_word(recv_cnt, SEED, NB)));
  assign exp_last = pkt_last(recv_cnt, num_lat,
                             PKT_WORDS);

  assign err_next =
    (mismatch && (err_count != 16'hFFFF)) ?
    err_count + 16'd1 : err_count;

  sb_incr_word_check #(
    .DW(DW)
  ) u_check (
    .clk      (clk),
    .rst      (rst),
    .fire     (rx_fire),
    .rx_data  (rx_data),
    .rx_last  (rx_last),
    .exp_data (exp_data),
    .exp_last (exp_last),
    .mismatch (mismatch)
  );

  // tx register: refill when empty or draining
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      tx_data  <= '0;
      send_cnt <= 16'd0;
    end else if (state != ST_RUN) begin
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      send_cnt <= 16'd0;
    end else if (!tx_valid || tx_ready) begin
      if (send_cnt < num_lat) begin
        tx_valid <= 1'b1;
        tx_data  <= nxt_data;
        tx_last  <= nxt_last;
        send_cnt <= send_cnt + 16'd1;
      end else begin
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
      end
    end
  end

  // run FSM, rx count, watchdog and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      num_lat   <= 16'd0;
      recv_cnt  <= 16'd0;
      wd_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 16'd0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_lat   <= num_words;
            recv_cnt  <= 16'd0;
            wd_cnt    <= '0;
            err_count <= 16'd0;
            timeout   <= 1'b0;
            if (num_words == 16'd0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          err_count <= err_next;
          if (rx_fire) begin
            recv_cnt <= recv_cnt + 16'd1;
          end
          if (all_recv) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0) &&
                     !timeout;
          end else if (tx_fire || rx_fire) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LAST) begin
            wd_cnt  <= wd_cnt + WDW'(1);
            timeout <= 1'b1;
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
